// File: rtl/seq_pkg.sv
// Shared definitions for the sequential library: FSM state encoding and a counter width helper.
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter width for a range of n values, never less than one bit.
    function automatic int unsigned CLOG2(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter with enable and a combinational zero flag.
module bit_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with valid/ready on the word side and ready-gated serial output.
module piso_serializer
    import seq_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         ser_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_last,
    output logic         busy
);

    localparam int unsigned CNT_W = CLOG2(N);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_shreg;
    logic [N-1:0] w_shreg_nxt;
    logic         w_cnt_zero;
    logic         w_shift;
    logic         w_load;
    logic         w_adv;
    logic         w_fin;

    assign w_shift = (r_state == ST_SHIFT);
    assign w_adv   = w_shift && ser_ready && !w_cnt_zero;
    assign w_fin   = w_shift && ser_ready && w_cnt_zero;

    // Accept a new word when idle or as the final bit is taken (zero-bubble reload).
    assign in_ready = rst && (!w_shift || w_fin);
    assign w_load   = in_valid && in_ready;

    bit_counter #(
        .W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_load),
        .i_load_val (CNT_W'(N - 1)),
        .i_en       (w_adv),
        .o_zero_c   (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Load has priority over finishing so back-to-back words stay in SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_shreg_nxt = in_data;
        end else if (w_adv) begin
            w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
        end else if (w_fin) begin
            w_state_nxt = ST_IDLE;
            w_shreg_nxt = '0;
        end
    end

    assign ser_valid = w_shift;
    assign busy      = w_shift;
    assign ser_last  = w_shift && w_cnt_zero;
    assign ser_out   = w_shift && (MSB_FIRST ? r_shreg[N-1] : r_shreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first, MSB-first and single-bit instances.
module tb_piso_serializer;

    logic clk;
    logic rst;

    logic [3:0] a_data;
    logic       a_valid, a_sready, a_iready, a_out, a_sv, a_last, a_busy;
    logic [3:0] b_data;
    logic       b_valid, b_sready, b_iready, b_out, b_sv, b_last, b_busy;
    logic [0:0] c_data;
    logic       c_valid, c_sready, c_iready, c_out, c_sv, c_last, c_busy;

    int checks;
    int failures;

    piso_serializer #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_iready),
        .ser_ready(a_sready), .ser_out(a_out), .ser_valid(a_sv), .ser_last(a_last), .busy(a_busy)
    );

    piso_serializer #(.N(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_iready),
        .ser_ready(b_sready), .ser_out(b_out), .ser_valid(b_sv), .ser_last(b_last), .busy(b_busy)
    );

    piso_serializer #(.N(1), .MSB_FIRST(1'b0)) u_n1 (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_iready),
        .ser_ready(c_sready), .ser_out(c_out), .ser_valid(c_sv), .ser_last(c_last), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        logic [4:0] obs;
        @(negedge clk);
        #1;
        checks++;
        obs = {a_out, a_sv, a_last, a_busy, a_iready};
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held got=%b exp=00000", obs);
        end
        checks++;
        obs = {b_iready, c_iready, b_sv, c_sv, 1'b0};
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held_others got=%b exp=00000", obs);
        end
        rst = 1'b1;
        #1;
        checks++;
        obs = {a_out, a_sv, a_last, a_busy, a_iready};
        if (obs !== 5'b00001) begin
            failures++;
            $display("FAIL reset_release got=%b exp=00001", obs);
        end
        // Load 1011, show two bits, then abort with reset mid-word.
        a_data = 4'b1011; a_valid = 1'b1; a_sready = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++;
        if ({a_sv, a_out} !== 2'b11) begin
            failures++;
            $display("FAIL abort_first_bit got=%b exp=11", {a_sv, a_out});
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        obs = {a_out, a_sv, a_last, a_busy, a_iready};
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL abort_immediate got=%b exp=00000", obs);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({a_sv, a_out, a_iready} !== 3'b001) begin
                failures++;
                $display("FAIL abort_no_bits cyc=%0d got=%b exp=001", i, {a_sv, a_out, a_iready});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_first;
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        a_data = 4'b1011; a_valid = 1'b1; a_sready = 1'b1;
        #1;
        checks++;
        if (a_iready !== 1'b1) begin
            failures++;
            $display("FAIL lsb_ready_idle got=%b exp=1", a_iready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = 1'b0;
            #1;
            checks++;
            if ({a_sv, a_out, a_last} !== {1'b1, exp_bits[i], (i == 3)}) begin
                failures++;
                $display("FAIL lsb_bit%0d got=%b exp=%b", i, {a_sv, a_out, a_last},
                         {1'b1, exp_bits[i], (i == 3)});
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({a_sv, a_busy, a_iready} !== 3'b001) begin
            failures++;
            $display("FAIL lsb_idle_after got=%b exp=001", {a_sv, a_busy, a_iready});
        end
    endtask

    task automatic test_msb_first;
        logic [3:0] exp_seq;
        exp_seq = 4'b1101;
        b_data = 4'b1011; b_valid = 1'b1; b_sready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_valid = 1'b0;
            #1;
            checks++;
            if ({b_sv, b_out, b_last} !== {1'b1, exp_seq[i], (i == 3)}) begin
                failures++;
                $display("FAIL msb_bit%0d got=%b exp=%b", i, {b_sv, b_out, b_last},
                         {1'b1, exp_seq[i], (i == 3)});
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (b_sv !== 1'b0) begin
            failures++;
            $display("FAIL msb_idle_after got=%b exp=0", b_sv);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_seq;
        logic [7:0] exp_rdy;
        exp_seq = 8'b1110_0001;
        exp_rdy = 8'b1000_1000;
        @(negedge clk);
        a_data = 4'b0001; a_valid = 1'b1; a_sready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) a_data = 4'b1110;
            if (i == 4) a_valid = 1'b0;
            #1;
            checks++;
            if ({a_sv, a_out, a_iready} !== {1'b1, exp_seq[i], exp_rdy[i]}) begin
                failures++;
                $display("FAIL b2b_bit%0d got=%b exp=%b", i, {a_sv, a_out, a_iready},
                         {1'b1, exp_seq[i], exp_rdy[i]});
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_sv !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_after got=%b exp=0", a_sv);
        end
    endtask

    task automatic test_backpressure;
        logic [6:0] exp_seq;
        logic [6:0] exp_rdy;
        logic [6:0] exp_last;
        exp_seq  = 7'b0111110;
        exp_rdy  = 7'b1000000;
        exp_last = 7'b1000000;
        @(negedge clk);
        a_data = 4'b0110; a_valid = 1'b1; a_sready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_valid  = 1'b0;
            a_sready = !(i >= 1 && i <= 3);
            #1;
            checks++;
            if ({a_sv, a_out, a_last, a_iready} !== {1'b1, exp_seq[i], exp_last[i], exp_rdy[i]}) begin
                failures++;
                $display("FAIL bp_cyc%0d got=%b exp=%b", i, {a_sv, a_out, a_last, a_iready},
                         {1'b1, exp_seq[i], exp_last[i], exp_rdy[i]});
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_sv !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle_after got=%b exp=0", a_sv);
        end
    endtask

    task automatic test_single_bit;
        logic [3:0] stream;
        stream = 4'b0101;
        @(negedge clk);
        c_data = 1'(stream[0]); c_valid = 1'b1; c_sready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) c_data = 1'(stream[i + 1]);
            else c_valid = 1'b0;
            #1;
            checks++;
            if ({c_sv, c_out, c_last, c_iready} !== {1'b1, stream[i], 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL n1_bit%0d got=%b exp=%b", i, {c_sv, c_out, c_last, c_iready},
                         {1'b1, stream[i], 1'b1, 1'b1});
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({c_sv, c_last} !== 2'b00) begin
            failures++;
            $display("FAIL n1_idle_after got=%b exp=00", {c_sv, c_last});
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        a_data = '0; a_valid = 1'b0; a_sready = 1'b0;
        b_data = '0; b_valid = 1'b0; b_sready = 1'b0;
        c_data = '0; c_valid = 1'b0; c_sready = 1'b0;
        test_reset;
        test_lsb_first;
        test_msb_first;
        test_back_to_back;
        test_backpressure;
        test_single_bit;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out stage that consumes the N-bit word held by the upstream parallel register and shifts it onto a single-bit line. It sits directly downstream of the PIPO register. A valid/ready handshake on the parallel side and a ready-gated serial side let it run back-to-back words with no bubble and stall cleanly under backpressure.

## Interface
- `N`, default 4: word width; legal range N >= 1.
- `MSB_FIRST`, default 0: 0 sends bit 0 first, 1 sends bit N-1 first.

- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  N  parallel word from the upstream register.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  word accepted on a clock edge where `in_valid && in_ready`.
- `ser_ready`  in  1  downstream takes the current bit on this edge.
- `ser_out`  out  1  current serial bit.
- `ser_valid`  out  1  `ser_out` is valid.
- `ser_last`  out  1  current bit is the final bit of the word.
- `busy`  out  1  a word is in flight; equals `ser_valid`.

## Operation
- Two states, held in `state`:
  - IDLE: no word in flight.
  - SHIFT: a word is being sent.
- Shift register `shreg[N-1:0]`; bit counter `cnt` of width max(1, clog2(N)), counting down from N-1.
- `ser_valid` = `busy` = (state == SHIFT).
- `ser_out` comes from `shreg[0]` (LSB-first) or `shreg[N-1]` (MSB-first). It is 0 in IDLE.
- `ser_last` = SHIFT && cnt == 0.
- `in_ready` = IDLE || (SHIFT && cnt == 0 && ser_ready). It is forced to 0 while `rst` is low.
- Load (`in_valid && in_ready`):
  - `shreg` <= `in_data`.
  - `cnt` <= N-1.
  - `state` <= SHIFT.
- Advance (SHIFT && `ser_ready` && cnt != 0):
  - `shreg` shifts one place toward the output end, filling with 0.
  - `cnt` <= cnt-1.
- Finish (SHIFT && `ser_ready` && cnt == 0):
  - With a simultaneous load: the load wins and state stays SHIFT (zero-bubble back-to-back).
  - Otherwise: `state` <= IDLE and `shreg` <= 0.
- Stall (SHIFT && !`ser_ready`): all state holds. `ser_out`, `ser_last` and `ser_valid` must stay stable.
- `in_valid` while busy and not at the last accepted bit is ignored. Upstream must hold the word; this block never drops an accepted word.
- N == 1: every word is a single bit with `ser_last` = 1. `in_ready` may be high every SHIFT cycle that has `ser_ready`.

## Timing
- Reset (`rst` low, asynchronous):
  - `state` = IDLE; `shreg` = 0; `cnt` = 0.
  - `ser_out` = 0, `ser_valid` = 0, `ser_last` = 0, `busy` = 0, `in_ready` = 0.
  - After release, `in_ready` = 1 in the first cycle.
- Reset mid-word aborts the word immediately. No partial bits are emitted after release.
- Latency: a word loaded at edge k shows bit 0 (per `MSB_FIRST`) after edge k. With `ser_ready` held high, the last bit is shown after edge k+N-1.
- Throughput: one word per N cycles with `ser_ready` continuously high.
- Outputs depend only on registered state, except `in_ready`, which is combinational from state and `ser_ready`.

## Structure
- Shared package/include `seq_pkg`:
  - state encoding localparams `ST_IDLE` = 1'b0 and `ST_SHIFT` = 1'b1.
  - a `CLOG2` function macro, reused by other counters in the sequential library.
- One sub-module, `bit_counter`:
  - parameterised down-counter with load, enable and a zero flag.
  - asynchronous active-low reset.
  - instantiated once for `cnt`.
- `shreg` and the FSM are inline in `piso_serializer`.

## Test plan
- Reset, then release with no `in_valid` -> all outputs 0 except `in_ready` = 1. Then assert `rst` mid-word with `in_data`=4'b1011 loaded -> outputs 0 immediately, no further bits.
- N=4, MSB_FIRST=0, load 4'b1011, `ser_ready`=1 -> `ser_out` 1,1,0,1 on 4 consecutive cycles; `ser_last` only on the 4th; then IDLE.
- MSB_FIRST=1, load 4'b1011 -> `ser_out` 1,0,1,1.
- Back-to-back: `in_valid` held with 4'b0001 then 4'b1110 -> 8 contiguous valid bits 1,0,0,0,0,1,1,1 with no gap. `in_ready` pulses only in the last-bit cycle.
- Backpressure: load 4'b0110, drop `ser_ready` for 3 cycles after the 2nd bit -> `ser_out`=1 held stable for 3 cycles, `in_ready`=0 throughout, sequence completes 0,1,1,0.
- N=1: stream 1,0,1 with `in_valid` and `ser_ready` high -> one bit per cycle, `ser_last`=1 every cycle.
